bus_ctrl_8288x: RTL and testbench
=================================

Name: bus_ctrl_8288x

Overview:
- Parametrised successor to the PC bus-command controller.
- Decodes the 3-bit CPU status into memory, I/O and interrupt-acknowledge commands using a full T1-T2-T3-TW-T4 bus-cycle sequencer.
- Adds READY-driven wait states, an optional wait timeout, normal and advanced write strobes, MCE for INTA, and back-to-back cycles with no idle clock.
- Sits between CPU status pins and system-bus transceivers/latches.

Parameters:
- WAIT_W, 4: width of the wait-state counter.
- MAX_WAIT, 15: maximum TW cycles before timeout (1..2^WAIT_W-1).
- ADV_WR, 1: 1 = amwc_n/aiowc_n use advanced timing (T2..end of write); 0 = they mirror mwtc_n/iowc_n timing.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- s_n  in  3  CPU status, active-low encoded
- aen_n  in  1  address enable; low permits a cycle start
- cen  in  1  command enable; low forces all commands inactive
- ready  in  1  memory/IO ready; low inserts wait states
- ale  out  1  address latch enable
- dtr  out  1  data direction; 1 = transmit, 0 = receive
- den  out  1  data transceiver enable
- mce  out  1  master cascade enable (INTA cycles)
- mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n  out  1 each  active-low commands
- busy  out  1  high when state != IDLE
- timeout  out  1  one-cycle pulse on wait timeout

Behaviour:
- Status decode:
  - 000 INTA
  - 001 IOR
  - 010 IOW
  - 011 HALT (ignored)
  - 100 code read and 101 MRD both map to MRD
  - 110 MWR
  - 111 passive (ignored)
- Start condition: state IDLE or T4, aen_n=0, and decoded status is a command.
  - On that clock edge, latch the one-hot command type, clear the wait counter, and move to T1.
  - Otherwise T4 goes to IDLE and IDLE stays in IDLE.
- State transitions:
  - IDLE: see start condition.
  - T1 -> T2.
  - T2 -> T3.
  - T3: ready=1 -> T4; else -> TW.
  - TW: ready=1 -> T4. Else, if BUSCTL_TIMEOUT_EN is defined and cnt==MAX_WAIT-1, -> T4 with timeout. Else stay in TW with cnt+1.
- Outputs are combinational from state and latched type, gated by cen.
- Outputs with cen=0:
  - All *_n outputs = 1.
  - ale=0, den=0, dtr=1, mce=0.
  - busy and timeout are unaffected.
- ale = 1 in T1 for any command.
- mce = 1 in T1 for INTA only.
- Read-type commands (mrdc_n, iorc_n, inta_n): low in T2, T3 and TW.
- Normal writes (mwtc_n, iowc_n): low in T3 and TW.
- Advanced writes (amwc_n, aiowc_n): low in T2, T3 and TW when ADV_WR=1; identical to the normal write when ADV_WR=0.
- dtr = 0 from T1 through T4 for read-type commands; 1 otherwise.
- den = 1 in T2, T3 and TW for all commands; 0 in IDLE, T1 and T4.
- Latched type holds from T1 to T4. Status changes on s_n outside IDLE/T4 are ignored.
- Back-to-back: T4 -> T1 directly. The previous command is already deasserted in T4, so there is never a cycle where two command outputs are low.
- aen_n rising mid-cycle does not abort the cycle; it only blocks the next start.
- Reset: asynchronous. State = IDLE, type cleared, cnt = 0, timeout = 0, all commands inactive. This applies mid-cycle too; command outputs release in the same cycle reset asserts.
- Wait counter saturates; it is never allowed to wrap.
- timeout is high only in the T4 that follows a forced exit.

Optional Feature:
- Macro: BUSCTL_TIMEOUT_EN.
- Defined: the TW limit above is enforced and the timeout pulse is produced.
- Undefined:
  - TW waits indefinitely for ready.
  - timeout is tied to 0.
  - No counter logic is synthesised; MAX_WAIT and WAIT_W are unused.

Test Plan:
- Zero-wait memory read (s_n=101, aen_n=0, ready=1, cen=1): T1 ale=1, dtr=0; T2 and T3 mrdc_n=0, den=1; T4 mrdc_n=1, den=0; next cycle IDLE, dtr=1, busy=0.
- Memory write, ADV_WR=1: amwc_n=0 in T2 and T3; mwtc_n=0 in T3 only; dtr=1 throughout. Repeat with ADV_WR=0: amwc_n low only in T3.
- I/O read with ready low 3 cycles after T3: iorc_n low for 5 cycles (T2, T3, 3×TW); T4 reached on the cycle after ready rises; timeout=0.
- BUSCTL_TIMEOUT_EN defined, MAX_WAIT=4, ready held 0: exactly 4 TW cycles, then T4 with timeout=1 for one cycle and iorc_n=1.
- Back-to-back INTA then MRD with s_n valid at T4: mce=1 and ale=1 in the first T1; the second T1 immediately follows T4; no overlap of inta_n and mrdc_n lows.
- rst pulsed during TW of a write: aiowc_n and iowc_n go to 1 asynchronously, busy=0, and the next cycle starts cleanly from IDLE. Also: cen=0 mid-read forces all commands to 1 while busy stays 1; s_n=111 and s_n=011 never start a cycle.

Source files
------------

// File: rtl/bus_ctrl_8288x.sv
// Bus-command controller: decodes CPU status into memory, I/O and INTA strobes through a T1-T2-T3-TW-T4 sequencer.
// Optional macro BUSCTL_TIMEOUT_EN bounds TW at MAX_WAIT cycles and raises a one-cycle timeout pulse in the forced T4.
module bus_ctrl_8288x #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15,
    parameter bit ADV_WR   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] s_n,
    input  logic       aen_n,
    input  logic       cen,
    input  logic       ready,
    output logic       ale,
    output logic       dtr,
    output logic       den,
    output logic       mce,
    output logic       mrdc_n,
    output logic       mwtc_n,
    output logic       amwc_n,
    output logic       iorc_n,
    output logic       iowc_n,
    output logic       aiowc_n,
    output logic       inta_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } state_t;

    // One-hot command type: [0] INTA, [1] IOR, [2] IOW, [3] MRD, [4] MWR
    localparam int TY_INTA = 0;
    localparam int TY_IOR  = 1;
    localparam int TY_IOW  = 2;
    localparam int TY_MRD  = 3;
    localparam int TY_MWR  = 4;

    if ((MAX_WAIT < 32'sd1) || (MAX_WAIT > ((32'sd1 <<< WAIT_W) - 32'sd1))) begin : g_bad_max_wait
        $error("bus_ctrl_8288x: MAX_WAIT must lie in 1..2**WAIT_W-1");
    end

    function automatic logic [4:0] decode_status(input logic [2:0] s);
        logic [4:0] d;
        d = 5'b00000;
        case (s)
            3'b000:         d = 5'b00001;
            3'b001:         d = 5'b00010;
            3'b010:         d = 5'b00100;
            3'b100, 3'b101: d = 5'b01000;
            3'b110:         d = 5'b10000;
            default:        d = 5'b00000;
        endcase
        return d;
    endfunction

    state_t      r_state;
    logic [4:0]  r_type;
    logic [4:0]  w_dec;
    logic        w_start;
    logic        w_t1;
    logic        w_win;
    logic        w_late;
    logic        w_adv;
    logic        w_rd;

`ifdef BUSCTL_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(MAX_WAIT - 1);
    logic [WAIT_W-1:0] r_cnt;
    logic              r_timeout;
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign w_dec   = decode_status(s_n);
    assign w_start = ((r_state == ST_IDLE) || (r_state == ST_T4)) && !aen_n && (w_dec != 5'b00000);
    assign w_t1    = (r_state == ST_T1);
    assign w_win   = (r_state == ST_T2) || (r_state == ST_T3) || (r_state == ST_TW);
    assign w_late  = (r_state == ST_T3) || (r_state == ST_TW);
    assign w_adv   = ADV_WR ? w_win : w_late;
    assign w_rd    = r_type[TY_INTA] | r_type[TY_IOR] | r_type[TY_MRD];
    assign busy    = (r_state != ST_IDLE);

    // Bus-cycle sequencer; the type latched in T1 is held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_type    <= 5'b00000;
`ifdef BUSCTL_TIMEOUT_EN
            r_cnt     <= {WAIT_W{1'b0}};
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef BUSCTL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_T4: begin
                    if (w_start) begin
                        r_state <= ST_T1;
                        r_type  <= w_dec;
`ifdef BUSCTL_TIMEOUT_EN
                        r_cnt   <= {WAIT_W{1'b0}};
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_T1: r_state <= ST_T2;
                ST_T2: r_state <= ST_T3;
                ST_T3: begin
                    if (ready) r_state <= ST_T4;
                    else       r_state <= ST_TW;
                end
                ST_TW: begin
                    if (ready) begin
                        r_state <= ST_T4;
`ifdef BUSCTL_TIMEOUT_EN
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_T4;
                        r_timeout <= 1'b1;
                    end else begin
                        r_state <= ST_TW;
                        // Saturate rather than wrap, even if MAX_WAIT sits at the counter ceiling.
                        if (r_cnt != {WAIT_W{1'b1}}) r_cnt <= r_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
                        else                         r_cnt <= r_cnt;
`else
                    end else begin
                        r_state <= ST_TW;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Command and transceiver outputs decoded from state and latched type, forced idle when cen is low.
    always_comb begin
        ale     = 1'b0;
        dtr     = 1'b1;
        den     = 1'b0;
        mce     = 1'b0;
        mrdc_n  = 1'b1;
        mwtc_n  = 1'b1;
        amwc_n  = 1'b1;
        iorc_n  = 1'b1;
        iowc_n  = 1'b1;
        aiowc_n = 1'b1;
        inta_n  = 1'b1;
        if (cen) begin
            ale     = w_t1;
            mce     = w_t1 & r_type[TY_INTA];
            den     = w_win;
            dtr     = !(busy && w_rd);
            inta_n  = !(w_win  & r_type[TY_INTA]);
            iorc_n  = !(w_win  & r_type[TY_IOR]);
            mrdc_n  = !(w_win  & r_type[TY_MRD]);
            iowc_n  = !(w_late & r_type[TY_IOW]);
            aiowc_n = !(w_adv  & r_type[TY_IOW]);
            mwtc_n  = !(w_late & r_type[TY_MWR]);
            amwc_n  = !(w_adv  & r_type[TY_MWR]);
        end else begin
            ale     = 1'b0;
            dtr     = 1'b1;
            den     = 1'b0;
            mce     = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_ctrl_8288x.sv
// Self-checking bench for bus_ctrl_8288x: two instances (ADV_WR=1 and ADV_WR=0, MAX_WAIT=4) against a transaction-position model.
module tb_bus_ctrl_8288x;

`ifdef BUSCTL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAXW = 4;

    logic       clk, rst, aen_n, cen, ready;
    logic [2:0] s_n;
    logic [1:0] ale, dtr, den, mce, mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n, busy, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int c_iorc, c_mrdc, c_to, c_idle, c_ale_mce;
    int c_amwc [2];

    // Model: m_k = clocks since T1, m_tw = wait cycles so far, m_done = sitting in the closing T4
    bit m_busy, m_done, m_to;
    int m_k, m_tw, m_type;

    bus_ctrl_8288x #(.WAIT_W(4), .MAX_WAIT(MAXW), .ADV_WR(1'b1)) dut_a (
        .clk(clk), .rst(rst), .s_n(s_n), .aen_n(aen_n), .cen(cen), .ready(ready),
        .ale(ale[1]), .dtr(dtr[1]), .den(den[1]), .mce(mce[1]), .mrdc_n(mrdc_n[1]),
        .mwtc_n(mwtc_n[1]), .amwc_n(amwc_n[1]), .iorc_n(iorc_n[1]), .iowc_n(iowc_n[1]),
        .aiowc_n(aiowc_n[1]), .inta_n(inta_n[1]), .busy(busy[1]), .timeout(timeout[1]));

    bus_ctrl_8288x #(.WAIT_W(4), .MAX_WAIT(MAXW), .ADV_WR(1'b0)) dut_b (
        .clk(clk), .rst(rst), .s_n(s_n), .aen_n(aen_n), .cen(cen), .ready(ready),
        .ale(ale[0]), .dtr(dtr[0]), .den(den[0]), .mce(mce[0]), .mrdc_n(mrdc_n[0]),
        .mwtc_n(mwtc_n[0]), .amwc_n(amwc_n[0]), .iorc_n(iorc_n[0]), .iowc_n(iowc_n[0]),
        .aiowc_n(aiowc_n[0]), .inta_n(inta_n[0]), .busy(busy[0]), .timeout(timeout[0]));

    always #5 clk = ~clk;

    // Type codes: 0 INTA, 1 IOR, 2 IOW, 3 MRD, 4 MWR, -1 no cycle
    function automatic int decode(input logic [2:0] s);
        case (s)
            3'b000:         return 0;
            3'b001:         return 1;
            3'b010:         return 2;
            3'b100, 3'b101: return 3;
            3'b110:         return 4;
            default:        return -1;
        endcase
    endfunction

    function automatic logic [12:0] got(input int i);
        return {ale[i], dtr[i], den[i], mce[i], mrdc_n[i], mwtc_n[i], amwc_n[i],
                iorc_n[i], iowc_n[i], aiowc_n[i], inta_n[i], busy[i], timeout[i]};
    endfunction

    function automatic logic [12:0] exp_out(input bit adv);
        bit t1, win, late, aw, rd;
        t1   = m_busy && !m_done && (m_k == 0);
        win  = m_busy && !m_done && (m_k >= 1);
        late = win && (m_k >= 2);
        aw   = adv ? win : late;
        rd   = (m_type == 0) || (m_type == 1) || (m_type == 3);
        if (cen)
            return {t1, !(m_busy && rd), win, t1 && (m_type == 0),
                    !(win && m_type == 3), !(late && m_type == 4), !(aw && m_type == 4),
                    !(win && m_type == 1), !(late && m_type == 2), !(aw && m_type == 2),
                    !(win && m_type == 0), m_busy, m_to};
        else
            return {1'b0, 1'b1, 1'b0, 1'b0, 7'b1111111, m_busy, m_to};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_to = 1'b0; m_k = 0; m_tw = 0; m_type = -1;
    endtask

    task automatic model_step();
        int c;
        if (rst) begin
            model_reset();
            return;
        end
        c = decode(s_n);
        m_to = 1'b0;
        if (!m_busy || m_done) begin
            if (!aen_n && c >= 0) begin
                m_busy = 1'b1; m_done = 1'b0; m_k = 0; m_tw = 0; m_type = c;
            end else begin
                m_busy = 1'b0; m_done = 1'b0;
            end
        end else if (m_k < 2) begin
            m_k++;
        end else begin
            m_k++;
            if (ready) m_done = 1'b1;
            else if (TO_EN && m_tw == MAXW) begin m_done = 1'b1; m_to = 1'b1; end
            else m_tw++;
        end
    endtask

    task automatic cycle(input string tag);
        logic [12:0] g, e;
        int lows;
        @(negedge clk);
        if (iorc_n[1] === 1'b0) c_iorc++;
        if (mrdc_n[1] === 1'b0) c_mrdc++;
        if (timeout[1] === 1'b1) c_to++;
        if (busy[1] === 1'b0) c_idle++;
        if (ale[1] === 1'b1 && mce[1] === 1'b1) c_ale_mce++;
        for (int i = 0; i < 2; i++) if (amwc_n[i] === 1'b0) c_amwc[i]++;
        for (int i = 0; i < 2; i++) begin
            g = got(i);
            e = exp_out(i == 1);
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s adv=%0d t=%0t got=%b exp=%b", tag, i, $time, g, e);
            end
        end
        lows = int'(!mrdc_n[1]) + int'(!mwtc_n[1]) + int'(!iorc_n[1]) + int'(!iowc_n[1]) + int'(!inta_n[1]);
        n_checks++;
        if (lows > 1) begin
            n_fail++;
            $display("FAIL %s_overlap t=%0t low_commands=%0d max=1", tag, $time, lows);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_counts();
        c_iorc = 0; c_mrdc = 0; c_to = 0; c_idle = 0; c_ale_mce = 0; c_amwc[0] = 0; c_amwc[1] = 0;
    endtask

    task automatic go_idle();
        s_n = 3'b111; aen_n = 1'b1;
    endtask

    task automatic test_reset();
        cycle("reset");
        cycle("reset");
        n_checks++;
        if ({busy, timeout, mrdc_n, iorc_n} !== 8'b00001111) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", {busy, timeout, mrdc_n, iorc_n}, 8'b00001111);
        end
        rst = 1'b0;
        cycle("post_reset");
    endtask

    task automatic test_zero_wait_read();
        clear_counts();
        s_n = 3'b101; aen_n = 1'b0; ready = 1'b1;
        cycle("mrd_start");
        go_idle();
        repeat (5) cycle("mrd");
        n_checks++;
        if (c_mrdc !== 2) begin n_fail++; $display("FAIL mrd_low_cycles got=%0d exp=2", c_mrdc); end
    endtask

    task automatic test_mem_write();
        clear_counts();
        s_n = 3'b110; aen_n = 1'b0; ready = 1'b1;
        cycle("mwr_start");
        go_idle();
        repeat (5) cycle("mwr");
        n_checks++;
        if (c_amwc[1] !== 2 || c_amwc[0] !== 1) begin
            n_fail++;
            $display("FAIL amwc_low_cycles got=%0d/%0d exp=2/1", c_amwc[1], c_amwc[0]);
        end
    endtask

    task automatic test_io_wait();
        clear_counts();
        s_n = 3'b001; aen_n = 1'b0; ready = 1'b0;
        cycle("ior_start");
        go_idle();
        repeat (5) cycle("ior_wait");
        ready = 1'b1;
        repeat (3) cycle("ior_end");
        n_checks++;
        if (c_iorc !== 5 || c_to !== 0) begin
            n_fail++;
            $display("FAIL ior_wait got=%0d,%0d exp=5,0", c_iorc, c_to);
        end
    endtask

`ifdef BUSCTL_TIMEOUT_EN
    task automatic test_timeout();
        clear_counts();
        s_n = 3'b001; aen_n = 1'b0; ready = 1'b0;
        cycle("to_start");
        go_idle();
        repeat (10) cycle("to");
        ready = 1'b1;
        n_checks++;
        if (c_iorc !== 6 || c_to !== 1) begin
            n_fail++;
            $display("FAIL timeout got=%0d,%0d exp=6,1", c_iorc, c_to);
        end
    endtask
`else
    task automatic test_timeout();
        clear_counts();
        s_n = 3'b001; aen_n = 1'b0; ready = 1'b0;
        cycle("hold_start");
        go_idle();
        repeat (30) cycle("hold");
        n_checks++;
        if (busy[1] !== 1'b1 || c_to !== 0) begin
            n_fail++;
            $display("FAIL hold_wait got=%b,%0d exp=1,0", busy[1], c_to);
        end
        ready = 1'b1;
        repeat (3) cycle("hold_end");
    endtask
`endif

    task automatic test_back_to_back();
        s_n = 3'b000; aen_n = 1'b0; ready = 1'b1;
        cycle("b2b_start");
        clear_counts();
        s_n = 3'b101;
        repeat (4) cycle("b2b_inta");
        go_idle();
        repeat (4) cycle("b2b_mrd");
        n_checks++;
        if (c_idle !== 0 || c_ale_mce !== 1 || c_mrdc !== 2) begin
            n_fail++;
            $display("FAIL b2b got=%0d,%0d,%0d exp=0,1,2", c_idle, c_ale_mce, c_mrdc);
        end
        cycle("b2b_idle");
    endtask

    task automatic test_reset_mid_cycle();
        s_n = 3'b010; aen_n = 1'b0; ready = 1'b0;
        cycle("rst_start");
        go_idle();
        repeat (4) cycle("rst_iow");
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({iowc_n, aiowc_n, busy} !== 6'b111100) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", {iowc_n, aiowc_n, busy}, 6'b111100);
        end
        model_reset();
        cycle("rst_hold");
        rst = 1'b0; ready = 1'b1;
        clear_counts();
        s_n = 3'b100; aen_n = 1'b0;
        cycle("rst_next");
        go_idle();
        repeat (5) cycle("rst_next");
        n_checks++;
        if (c_mrdc !== 2) begin n_fail++; $display("FAIL restart_read got=%0d exp=2", c_mrdc); end
    endtask

    task automatic test_cen_gate();
        s_n = 3'b101; aen_n = 1'b0; ready = 1'b1;
        cycle("cen_start");
        go_idle();
        cycle("cen_t1");
        cen = 1'b0;
        cycle("cen_off");
        n_checks++;
        if ({mrdc_n[1], den[1], dtr[1], busy[1]} !== 4'b1011) begin
            n_fail++;
            $display("FAIL cen_gate got=%b exp=%b", {mrdc_n[1], den[1], dtr[1], busy[1]}, 4'b1011);
        end
        cen = 1'b1;
        repeat (3) cycle("cen_on");
    endtask

    task automatic test_no_start();
        go_idle();
        repeat (2) cycle("ns_pre");
        clear_counts();
        aen_n = 1'b0; s_n = 3'b111;
        repeat (3) cycle("ns_passive");
        s_n = 3'b011;
        repeat (3) cycle("ns_halt");
        n_checks++;
        if (c_idle !== 6) begin n_fail++; $display("FAIL no_start idle_cycles got=%0d exp=6", c_idle); end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            s_n   = 3'($urandom_range(0, 7));
            aen_n = ($urandom_range(0, 3) == 0);
            cen   = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 2) != 0);
            cycle("random");
        end
        cen = 1'b1; ready = 1'b1; go_idle();
        repeat (12) cycle("random_drain");
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; s_n = 3'b111; aen_n = 1'b1; cen = 1'b1; ready = 1'b1;
        model_reset();
        clear_counts();
        test_reset();
        test_zero_wait_read();
        test_mem_write();
        test_io_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid_cycle();
        test_cen_gate();
        test_no_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
